// File: rtl/led_meter_ctrl.sv
// Audio bar-graph meter: sample magnitude quantised to a 4-bit level that decays once per tick.
// Optional peak-hold marker selected by macro LED_METER_PEAK_HOLD_EN.
module led_meter_ctrl #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned HOLD_TICKS = 50
) (
    input  logic        clk,
    input  logic        RESET_n,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    output logic [3:0]  level,
    output logic [3:0]  peak,
    output logic        clip,
    output logic        tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

    logic [15:0]      abs_s;
    logic [14:0]      mag;
    logic [3:0]       q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [3:0]       level_q, level_d;
    logic             clip_q, clip_d;

    // Magnitude with -32768 saturated to full scale, then quantise.
    always_comb begin
        abs_s = sample[15] ? (~sample + 16'd1) : sample;
        mag   = abs_s[15] ? 15'h7FFF : abs_s[14:0];
        q     = mag[14:11];
    end

    // Prescaler, level attack/decay and clip detect.
    always_comb begin
        cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        tick_d  = (cnt_q == CNT_MAX);
        clip_d  = sample_valid && (mag == 15'h7FFF);
        level_d = level_q;
        if (sample_valid && (q >= level_q)) begin
            level_d = q;
        end else if (tick_q && (level_q != 4'd0)) begin
            level_d = level_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            level_q <= 4'd0;
            clip_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            level_q <= level_d;
            clip_q  <= clip_d;
        end
    end

    assign level = level_q;
    assign clip  = clip_q;
    assign tick  = tick_q;

`ifdef LED_METER_PEAK_HOLD_EN
    typedef enum logic [1:0] {TRACK, HOLD, FALL} peak_state_e;

    peak_state_e state_q, state_d;
    logic [3:0]  peak_q, peak_d;
    logic [7:0]  hold_q, hold_d;
    logic [3:0]  p_fall;

    // A new higher sample always wins; otherwise each state applies its tick action.
    always_comb begin
        state_d = state_q;
        peak_d  = peak_q;
        hold_d  = hold_q;
        p_fall  = peak_q;
        if (sample_valid && (q > peak_q)) begin
            peak_d  = q;
            hold_d  = HOLD_INIT;
            state_d = HOLD;
        end else begin
            case (state_q)
                TRACK: peak_d = level_d;
                HOLD: begin
                    if (sample_valid && (q == peak_q)) begin
                        hold_d = HOLD_INIT;
                    end else if (tick_q) begin
                        hold_d = hold_q - 8'd1;
                        if (hold_q == 8'd1) state_d = FALL;
                    end
                end
                FALL: begin
                    if (!(sample_valid && (q == peak_q))) begin
                        p_fall = (tick_q && (peak_q != 4'd0)) ? peak_q - 4'd1 : peak_q;
                        if (p_fall <= level_d) begin
                            peak_d  = level_d;
                            state_d = TRACK;
                        end else begin
                            peak_d = p_fall;
                        end
                    end
                end
                default: state_d = TRACK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            state_q <= TRACK;
            peak_q  <= 4'd0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            peak_q  <= peak_d;
            hold_q  <= hold_d;
        end
    end

    assign peak = peak_q;
`else
    assign peak = level_q;
`endif

endmodule

// File: tb/tb_led_meter_ctrl.sv
// Directed bench for led_meter_ctrl with TICK_DIV=4, HOLD_TICKS=2; peak expectations follow LED_METER_PEAK_HOLD_EN.
module tb_led_meter_ctrl;

    logic        clk = 1'b0;
    logic        RESET_n;
    logic        sample_valid;
    logic [15:0] sample;
    logic [3:0]  level;
    logic [3:0]  peak;
    logic        clip;
    logic        tick;

    int n_pass  = 0;
    int n_total = 0;

    led_meter_ctrl #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
        .clk          (clk),
        .RESET_n      (RESET_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .level        (level),
        .peak         (peak),
        .clip         (clip),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Expected peak: held value when the feature is built, otherwise the level.
    function automatic logic [7:0] epk(input logic [7:0] ph, input logic [7:0] lv);
`ifdef LED_METER_PEAK_HOLD_EN
        return ph;
`else
        return lv;
`endif
    endfunction

    task automatic step(input logic v, input logic [15:0] s);
        sample_valid = v;
        sample       = s;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample       = 16'h0000;
    endtask

    logic [7:0] exp_lvl [10];
    logic [7:0] exp_pk  [10];

    initial begin
        exp_lvl = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
        exp_pk  = '{8'd8, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        RESET_n      = 1'b0;
        sample_valid = 1'b0;
        sample       = 16'h0000;
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0000);
        check("rst_level", 8'(level), 8'd0);
        check("rst_peak",  8'(peak),  8'd0);
        check("rst_clip",  8'(clip),  8'd0);
        check("rst_tick",  8'(tick),  8'd0);

        // Idle after release: tick every 4th cycle, first at cycle 4.
        RESET_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step(1'b0, 16'h0000);
            check($sformatf("idle_tick_c%0d", c), 8'(tick), (c % 4 == 0) ? 8'd1 : 8'd0);
        end
        check("idle_level", 8'(level), 8'd0);
        check("idle_peak",  8'(peak),  8'd0);

        // Attack to 8, coinciding with a tick (attack wins).
        step(1'b1, 16'h4000);
        check("att_level", 8'(level), 8'd8);
        check("att_peak",  8'(peak),  8'd8);
        check("att_clip",  8'(clip),  8'd0);

        // Decay of level, hold then fall of peak, one check per decay edge.
        for (int k = 0; k < 10; k++) begin
            repeat (4) step(1'b0, 16'h0000);
            check($sformatf("dec_level_%0d", k), 8'(level), exp_lvl[k]);
            check($sformatf("dec_peak_%0d", k),  8'(peak),  epk(exp_pk[k], exp_lvl[k]));
        end

        // Clip on -32768 and +32767, not on 32766.
        step(1'b1, 16'h8000);
        check("clip_neg_level", 8'(level), 8'd15);
        check("clip_neg_peak",  8'(peak),  8'd15);
        check("clip_neg",       8'(clip),  8'd1);
        step(1'b0, 16'h0000);
        check("clip_pulse_end", 8'(clip),  8'd0);
        step(1'b1, 16'h7FFF);
        check("clip_pos",       8'(clip),  8'd1);
        step(1'b1, 16'h7FFE);
        check("clip_none",      8'(clip),  8'd0);
        check("clip_none_lvl",  8'(level), 8'd15);

        // Reset mid-HOLD with peak at 12.
        RESET_n = 1'b0;
        step(1'b0, 16'h0000);
        RESET_n = 1'b1;
        step(1'b1, 16'h6000);
        check("h12_level", 8'(level), 8'd12);
        check("h12_peak",  8'(peak),  8'd12);
        RESET_n = 1'b0;
        step(1'b1, 16'h7FFF);
        check("rst2_level", 8'(level), 8'd0);
        check("rst2_peak",  8'(peak),  8'd0);
        check("rst2_clip",  8'(clip),  8'd0);
        check("rst2_tick",  8'(tick),  8'd0);
        RESET_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 16'h0000);
            check($sformatf("rst2_tick_c%0d", c), 8'(tick), (c == 4) ? 8'd1 : 8'd0);
        end

        // Sample/tick coincidence at level 5.
        step(1'b1, 16'h2800);
        check("l5_level", 8'(level), 8'd5);
        repeat (3) step(1'b0, 16'h0000);
        check("l5_tick_a", 8'(tick), 8'd1);
        step(1'b1, 16'h2800);
        check("eq_tick_level", 8'(level), 8'd5);
        check("eq_tick_peak",  8'(peak),  8'd5);
        repeat (3) step(1'b0, 16'h0000);
        check("l5_tick_b", 8'(tick), 8'd1);
        step(1'b1, 16'h1800);
        check("low_tick_level", 8'(level), 8'd4);
        check("low_tick_peak",  8'(peak),  epk(8'd5, 8'd4));

        // Hold expires, peak falls, equal sample in FALL, then peak meets level.
        repeat (4) step(1'b0, 16'h0000);
        check("fall_in_level", 8'(level), 8'd3);
        check("fall_in_peak",  8'(peak),  epk(8'd5, 8'd3));
        repeat (4) step(1'b0, 16'h0000);
        check("fall1_level", 8'(level), 8'd2);
        check("fall1_peak",  8'(peak),  epk(8'd4, 8'd2));
        step(1'b1, 16'h2000);
        check("fall_eq_level", 8'(level), 8'd4);
        check("fall_eq_peak",  8'(peak),  8'd4);
        repeat (3) step(1'b0, 16'h0000);
        check("meet_level", 8'(level), 8'd3);
        check("meet_peak",  8'(peak),  8'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
